pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Port CLK  input  1  is the single system clock; all state updates on its rising edge.
REQ-003 Port Reset  input  1  is the reset, synchronous and active-high.
REQ-004 Port PCWre  input  1  is the PC write enable; 1 = advance PC this cycle.
REQ-005 Port PCSrc  input  2  selects the next-PC source: 00 sequential, 01 branch, 10 jump, 11 register.
REQ-006 Port Halt  input  1  requests a stop (halt instruction decoded).
REQ-007 Port ExtOffset  input  32  is the branch offset already shifted left by 2 by the upstream Shift stage.
REQ-008 Port JumpAddr  input  26  is the instruction jump field.
REQ-009 Port RegTarget  input  32  is the register jump target.
REQ-010 Port curPC  output  32  is the registered current PC.
REQ-011 Port nextPC  output  32  is combinational curPC+4.
REQ-012 Port State  output  2  is the FSM state: 00 RUN, 01 HALT, 10 ERR.
REQ-013 Port AddrErr  output  1  is a sticky misaligned-target flag.
REQ-014 Port InstCount  output  32  counts accepted PC updates.

Function
REQ-015 The block SHALL compute the target as follows:
- PCSrc 00: curPC+4.
- PCSrc 01: curPC+4+ExtOffset.
- PCSrc 10: {nextPC[31:28], JumpAddr, 2'b00}.
- PCSrc 11: RegTarget.
- All sums are modulo 2^32; overflow wraps silently.
REQ-016 In RUN with PCWre=1, Halt=0 and target[1:0]==00, curPC SHALL load the target at the next rising edge (1-cycle latency), and InstCount SHALL increment by 1.
REQ-017 In RUN with PCWre=0 and Halt=0, curPC, InstCount and State SHALL hold.
REQ-018 In RUN with Halt=1, the FSM SHALL enter HALT at the next edge. Halt takes priority over PCWre and the target check; curPC and InstCount hold.
REQ-019 In RUN with PCWre=1, Halt=0 and target[1:0]!=00, the block SHALL respond at the next edge as follows:
- curPC holds.
- InstCount holds.
- AddrErr is set to 1.
- State goes to ERR.
REQ-020 HALT and ERR SHALL be absorbing: curPC, InstCount and AddrErr hold regardless of PCWre, PCSrc or Halt until Reset.
REQ-021 InstCount SHALL saturate at 32'hFFFF_FFFF: an accepted update at saturation advances curPC but leaves InstCount unchanged.
REQ-022 nextPC SHALL always equal curPC+4 (mod 2^32) in every state, with zero latency.
REQ-023 PCSrc values SHALL be decoded fully; no input combination produces X on any output.

Reset
REQ-024 When Reset=1 at a rising edge, the block SHALL set:
- curPC = RESET_PC
- InstCount = 0
- AddrErr = 0
- State = RUN
REQ-025 Reset SHALL take priority over Halt, PCWre and error detection in every state, including mid-operation in HALT and ERR.
REQ-026 No output SHALL change asynchronously on Reset assertion; the effect appears only at the next rising CLK edge.

Verification
REQ-027 Sequential: Reset, then PCWre=1, PCSrc=00 for 3 cycles -> curPC 0, 4, 8, 0xC; InstCount=3; nextPC=0x10.
REQ-028 Branch: curPC=0x10, PCSrc=01, ExtOffset=0xFFFF_FFF8 (-8 after shift) -> curPC=0x0C. Repeat with ExtOffset=0x0000_0018 -> curPC=0x28.
REQ-029 Jump: curPC=0x4000_0000, PCSrc=10, JumpAddr=26'h0000_040 -> curPC=0x4000_0100.
REQ-030 Error: PCSrc=11, RegTarget=0x0000_0006, PCWre=1 -> next edge State=ERR, AddrErr=1, curPC unchanged. Further PCWre pulses have no effect. Reset -> curPC=0, AddrErr=0, State=RUN.
REQ-031 Halt priority and stall: Halt=1 together with PCWre=1 -> State=HALT, curPC and InstCount unchanged. PCWre=0 in RUN for 5 cycles -> all outputs stable. Reset asserted while in HALT -> RUN, curPC=RESET_PC.
REQ-032 Wrap and saturation: curPC=0xFFFF_FFFC with PCSrc=00 -> curPC=0x0000_0000. With InstCount forced to 0xFFFF_FFFF, an accepted update advances curPC while InstCount stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter unit: next-PC selection, alignment checking, halt/error FSM
// and a saturating count of accepted PC updates.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        Halt,
    input  logic [31:0] ExtOffset,
    input  logic [25:0] JumpAddr,
    input  logic [31:0] RegTarget,
    output logic [31:0] curPC,
    output logic [31:0] nextPC,
    output logic [1:0]  State,
    output logic        AddrErr,
    output logic [31:0] InstCount
);

    localparam int unsigned XLEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        ERR  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inst_count_q, inst_count_d;
    logic              addr_err_q, addr_err_d;
    logic [XLEN-1:0]   seq_pc;
    logic [XLEN-1:0]   target;

    assign seq_pc = pc_q + PC_STEP;

    // Candidate next PC; all four sources are decoded so no encoding yields X.
    always_comb begin
        target = seq_pc;
        case (PCSrc)
            2'b00:   target = seq_pc;
            2'b01:   target = seq_pc + ExtOffset;
            2'b10:   target = {seq_pc[31:28], JumpAddr, 2'b00};
            2'b11:   target = RegTarget;
            default: target = seq_pc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            inst_count_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_count_q <= inst_count_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Halt outranks the write enable; a misaligned target parks the unit in ERR.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_count_d = inst_count_q;
        addr_err_d   = addr_err_q;
        case (state_q)
            RUN: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (PCWre) begin
                    if (target[1:0] != 2'b00) begin
                        state_d    = ERR;
                        addr_err_d = 1'b1;
                    end else begin
                        pc_d = target;
                        if (inst_count_q != CNT_MAX) begin
                            inst_count_d = inst_count_q + 32'd1;
                        end
                    end
                end
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    assign curPC     = pc_q;
    assign nextPC    = seq_pc;
    assign State     = state_q;
    assign AddrErr   = addr_err_q;
    assign InstCount = inst_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the PC rules.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        Halt;
    logic [31:0] ExtOffset;
    logic [25:0] JumpAddr;
    logic [31:0] RegTarget;
    logic [31:0] curPC;
    logic [31:0] nextPC;
    logic [1:0]  State;
    logic        AddrErr;
    logic [31:0] InstCount;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [1:0]  st;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: mode 0 = running, 1 = halted, 2 = error.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;
    int          m_mode;
    bit          m_known = 1'b0;

    always #5 CLK = ~CLK;

    pc_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .Halt      (Halt),
        .ExtOffset (ExtOffset),
        .JumpAddr  (JumpAddr),
        .RegTarget (RegTarget),
        .curPC     (curPC),
        .nextPC    (nextPC),
        .State     (State),
        .AddrErr   (AddrErr),
        .InstCount (InstCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising edge the DUT presents new state; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_curPC",     curPC,             e.pc);
                chk("sb_nextPC",    nextPC,            e.pc + 32'd4);
                chk("sb_State",     {30'b0, State},    {30'b0, e.st});
                chk("sb_AddrErr",   {31'b0, AddrErr},  {31'b0, e.err});
                chk("sb_InstCount", InstCount,         e.cnt);
            end
        end
    end

    // Drive one cycle of inputs, advance the model, and queue the expected post-edge state.
    task automatic step(input logic rst, input logic we, input logic hlt, input logic [1:0] src,
                        input logic [31:0] off, input logic [25:0] ja, input logic [31:0] rt,
                        input bit sat);
        logic [31:0] t;
        exp_t e;
        @(negedge CLK);
        Reset     = rst;
        PCWre     = we;
        Halt      = hlt;
        PCSrc     = src;
        ExtOffset = off;
        JumpAddr  = ja;
        RegTarget = rt;
        if (sat) begin
            force dut.inst_count_q = 32'hFFFF_FFFF;
            #1;
            release dut.inst_count_q;
            m_cnt = 32'hFFFF_FFFF;
        end
        #1;
        if (m_known) begin
            chk("pre_edge_curPC",  curPC,  m_pc);
            chk("pre_edge_nextPC", nextPC, m_pc + 32'd4);
        end
        if (rst) begin
            m_pc    = RESET_PC;
            m_cnt   = 32'd0;
            m_err   = 1'b0;
            m_mode  = 0;
            m_known = 1'b1;
        end else if (m_mode == 0 && hlt) begin
            m_mode = 1;
        end else if (m_mode == 0 && we) begin
            case (src)
                2'd0:    t = m_pc + 32'd4;
                2'd1:    t = m_pc + 32'd4 + off;
                2'd2:    t = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, ja} << 2);
                default: t = rt;
            endcase
            if (t % 4 != 0) begin
                m_mode = 2;
                m_err  = 1'b1;
            end else begin
                m_pc = t;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
        end
        e.pc  = m_pc;
        e.cnt = m_cnt;
        e.st  = 2'(m_mode);
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic rst_step();
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0, 1'b0);
    endtask

    task automatic seq_step();
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0, 1'b0);
    endtask

    task automatic reg_step(input logic [31:0] rt);
        step(1'b0, 1'b1, 1'b0, 2'd3, 32'd0, 26'd0, rt, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_rst, r_we, r_hlt;
        logic [1:0]  r_src;
        logic [31:0] r_off, r_rt;
        logic [25:0] r_ja;

        Reset = 1'b1; PCWre = 1'b0; Halt = 1'b0; PCSrc = 2'd0;
        ExtOffset = '0; JumpAddr = '0; RegTarget = '0;

        rst_step();
        settle();
        chk("reset_curPC",     curPC,            RESET_PC);
        chk("reset_InstCount", InstCount,        32'd0);
        chk("reset_State",     {30'b0, State},   32'd0);
        chk("reset_AddrErr",   {31'b0, AddrErr}, 32'd0);

        repeat (3) seq_step();
        settle();
        chk("seq_curPC",     curPC,     32'h0000_000C);
        chk("seq_InstCount", InstCount, 32'd3);
        chk("seq_nextPC",    nextPC,    32'h0000_0010);

        seq_step();
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFF8, 26'd0, 32'd0, 1'b0);
        settle();
        chk("branch_back_curPC", curPC, 32'h0000_000C);
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0018, 26'd0, 32'd0, 1'b0);
        settle();
        chk("branch_fwd_curPC", curPC, 32'h0000_0028);

        reg_step(32'h4000_0000);
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'd0, 26'h0000_040, 32'd0, 1'b0);
        settle();
        chk("jump_curPC", curPC, 32'h4000_0100);

        reg_step(32'h0000_0006);
        settle();
        chk("err_State",   {30'b0, State},   32'd2);
        chk("err_AddrErr", {31'b0, AddrErr}, 32'd1);
        chk("err_curPC",   curPC,            32'h4000_0100);
        repeat (3) seq_step();
        step(1'b0, 1'b1, 1'b1, 2'd3, 32'd0, 26'd0, 32'h0000_0100, 1'b0);
        settle();
        chk("err_absorb_curPC", curPC,          32'h4000_0100);
        chk("err_absorb_State", {30'b0, State}, 32'd2);
        rst_step();
        settle();
        chk("err_reset_curPC",   curPC,            RESET_PC);
        chk("err_reset_AddrErr", {31'b0, AddrErr}, 32'd0);
        chk("err_reset_State",   {30'b0, State},   32'd0);

        seq_step();
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 1'b0);
        settle();
        chk("halt_State",     {30'b0, State}, 32'd1);
        chk("halt_curPC",     curPC,          32'h0000_0004);
        chk("halt_InstCount", InstCount,      32'd1);
        repeat (2) seq_step();
        rst_step();
        settle();
        chk("halt_reset_State", {30'b0, State}, 32'd0);
        chk("halt_reset_curPC", curPC,          RESET_PC);

        seq_step();
        repeat (5) step(1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0040, 26'h3FF_FFFF, 32'h0000_0007, 1'b0);
        settle();
        chk("stall_curPC",     curPC,          32'h0000_0004);
        chk("stall_InstCount", InstCount,      32'd1);
        chk("stall_State",     {30'b0, State}, 32'd0);

        reg_step(32'hFFFF_FFFC);
        seq_step();
        settle();
        chk("wrap_curPC", curPC, 32'h0000_0000);

        step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0, 1'b1);
        seq_step();
        settle();
        chk("sat_InstCount", InstCount, 32'hFFFF_FFFF);
        chk("sat_curPC",     curPC,     32'h0000_0004);

        rst_step();
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(19) == 0) || (m_mode != 0 && $urandom_range(3) == 0);
            r_hlt = ($urandom_range(29) == 0);
            r_we  = ($urandom_range(3) != 0);
            r_src = 2'($urandom_range(3));
            r_off = ($urandom_range(7) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            r_ja  = 26'($urandom);
            r_rt  = ($urandom_range(7) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            step(r_rst, r_we, r_hlt, r_src, r_off, r_ja, r_rt, 1'b0);
        end
        settle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
